// File: rtl/simon_cfg_key_loader.sv
// AXI4-Lite write initiator that streams KEY_WORDS key words into the simon cfg slave port
// at consecutive word addresses, one outstanding transaction at a time.
module simon_cfg_key_loader #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PROT_WIDTH = 1,
  parameter int unsigned RESP_WIDTH = 2,
  parameter int unsigned KEY_WORDS  = 8,
  localparam int unsigned IDX_W      = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  localparam int unsigned KEY_W      = KEY_WORDS * DATA_WIDTH
) (
  input  logic                  clk_simon_cfg,
  input  logic                  rst_simon_cfg,
  input  logic                  start,
  input  logic [KEY_W-1:0]      key,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [IDX_W-1:0]      err_idx,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [PROT_WIDTH-1:0] awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [RESP_WIDTH-1:0] bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [KEY_W-1:0]      r_key;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [IDX_W-1:0]      r_err_idx;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic                  r_awvalid;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wvalid;
  logic                  r_bready;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_fin;
  logic w_w_fin;
  logic w_b_hs;

  assign w_aw_hs  = r_awvalid & awready;
  assign w_w_hs   = r_wvalid & wready;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | w_w_hs;
  assign w_b_hs   = r_bready & bvalid;

  // r_key holds the words not yet presented; the next word is always its low slice.
  always_ff @(posedge clk_simon_cfg or negedge rst_simon_cfg) begin
    if (!rst_simon_cfg) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_key     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
      r_awaddr  <= '0;
      r_awvalid <= 1'b0;
      r_wdata   <= '0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key     <= key >> DATA_WIDTH;
            r_wdata   <= key[DATA_WIDTH-1:0];
            r_awaddr  <= base_addr;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
            r_busy    <= 1'b1;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= S_XFER;
          end
        end
        S_XFER: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_aw_done <= w_aw_fin;
            r_w_done  <= w_w_fin;
          end
        end
        S_RESP: begin
          if (w_b_hs) begin
            r_bready <= 1'b0;
            if (bresp != '0) begin
              r_err <= 1'b1;
              if (!r_err) r_err_idx <= r_idx;
            end
            if (r_idx == LAST_IDX) begin
              r_state <= S_DONE;
            end else begin
              r_idx     <= r_idx + IDX_W'(1);
              r_awaddr  <= r_awaddr + ADDR_WIDTH'(4);
              r_wdata   <= r_key[DATA_WIDTH-1:0];
              r_key     <= r_key >> DATA_WIDTH;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_XFER;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign err_idx = r_err_idx;
  assign awaddr  = r_awaddr;
  assign awprot  = '0;
  assign awvalid = r_awvalid;
  assign wdata   = r_wdata;
  assign wstrb   = '1;
  assign wvalid  = r_wvalid;
  assign bready  = r_bready;

endmodule

// File: tb/tb_simon_cfg_key_loader.sv
// Directed bench for simon_cfg_key_loader: a configurable-latency AXI4-Lite slave, a write
// logger with protocol monitors, and a linear sequence of load scenarios.
module tb_simon_cfg_key_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] key;
  logic [31:0]  base_addr;
  logic         busy, done, err;
  logic [2:0]   err_idx;
  logic [31:0]  awaddr;
  logic [0:0]   awprot;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready = 1'b0;
  logic [1:0]   bresp = 2'b00;
  logic         bvalid = 1'b0;
  logic         bready;

  always #5 clk = ~clk;

  simon_cfg_key_loader dut (
    .clk_simon_cfg(clk), .rst_simon_cfg(rst_n), .start(start), .key(key),
    .base_addr(base_addr), .busy(busy), .done(done), .err(err), .err_idx(err_idx),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // slave knobs and scoreboard state
  int          aw_lat = 0, w_lat = 0, aw_cnt = 0, w_cnt = 0;
  logic [7:0]  bad_mask = 8'h00;
  int          b_base = 0;
  logic [31:0] aw_log [0:127];
  logic [31:0] w_log  [0:127];
  int          aw_n = 0, w_n = 0, b_n = 0, proto_err = 0, stab_err = 0;
  logic        st_aw = 1'b0, st_w = 1'b0, p_aw_hs = 1'b0, p_w_hs = 1'b0;
  logic [31:0] p_awaddr = '0, p_wdata = '0;
  int          n_pass = 0, n_total = 0;
  logic [255:0] cur_k;
  logic [31:0]  cur_b;
  int           cur_a, cur_wa;

  // slave: readies after a programmable stall, B answered in the cycle after bready rises
  always @(negedge clk) begin
    int bi;
    if (awvalid) begin
      if (aw_cnt >= aw_lat) awready = 1'b1;
      else begin awready = 1'b0; aw_cnt = aw_cnt + 1; end
    end else begin awready = 1'b0; aw_cnt = 0; end
    if (wvalid) begin
      if (w_cnt >= w_lat) wready = 1'b1;
      else begin wready = 1'b0; w_cnt = w_cnt + 1; end
    end else begin wready = 1'b0; w_cnt = 0; end
    bi = b_n - b_base;
    bvalid = bready;
    bresp = (bready && bi >= 0 && bi < 8 && bad_mask[bi[2:0]]) ? 2'b10 : 2'b00;
  end

  // monitor: logs handshakes and counts ordering/stability violations
  always @(posedge clk) begin
    if (!rst_n) begin
      st_aw = 1'b0; st_w = 1'b0; p_aw_hs = 1'b0; p_w_hs = 1'b0;
    end else begin
      if (st_aw && (!awvalid || awaddr != p_awaddr)) stab_err = stab_err + 1;
      if (st_w && (!wvalid || wdata != p_wdata)) stab_err = stab_err + 1;
      if (p_aw_hs && awvalid) proto_err = proto_err + 1;
      if (p_w_hs && wvalid) proto_err = proto_err + 1;
      if (bready && (aw_n != b_n + 1 || w_n != b_n + 1)) proto_err = proto_err + 1;
      st_aw = awvalid && !awready;  p_awaddr = awaddr;
      st_w  = wvalid && !wready;    p_wdata  = wdata;
      p_aw_hs = awvalid && awready;
      p_w_hs  = wvalid && wready;
      if (awvalid && awready) begin
        if (aw_n != b_n) proto_err = proto_err + 1;
        if (aw_n < 128) aw_log[aw_n] = awaddr;
        aw_n = aw_n + 1;
      end
      if (wvalid && wready) begin
        if (w_n != b_n) proto_err = proto_err + 1;
        if (w_n < 128) w_log[w_n] = wdata;
        w_n = w_n + 1;
      end
      if (bvalid && bready) b_n = b_n + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic begin_load(input logic [255:0] k, input logic [31:0] b, input logic [7:0] mask);
    bad_mask = mask; cur_k = k; cur_b = b; cur_a = aw_n; cur_wa = w_n; b_base = b_n;
    @(negedge clk); key = k; base_addr = b; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("awvalid_after_start", 64'(awvalid), 64'd1);
    check("wvalid_after_start", 64'(wvalid), 64'd1);
    check("awaddr_word0", 64'(awaddr), 64'(b));
    check("wdata_word0", 64'(wdata), 64'(k[31:0]));
    check("err_clear_on_start", 64'(err), 64'd0);
  endtask

  // counts cycles from the start edge to done and checks the full write log of the load
  task automatic end_load(input int exp_lat, input int poke, input logic exp_err, input logic [2:0] exp_idx);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk); n = n + 1;
      if (poke != 0 && n == poke) begin key = ~cur_k; start = 1'b1; end
      else start = 1'b0;
    end
    check("done_latency", 64'(n), 64'(exp_lat));
    check("busy_at_done", 64'(busy), 64'd0);
    check("err_at_done", 64'(err), 64'(exp_err));
    if (exp_err) check("err_idx_at_done", 64'(err_idx), 64'(exp_idx));
    check("aw_count", 64'(aw_n - cur_a), 64'd8);
    check("w_count", 64'(w_n - cur_wa), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("awaddr_w%0d", i), 64'(aw_log[cur_a + i]), 64'(32'(cur_b + 32'(4 * i))));
      check($sformatf("wdata_w%0d", i), 64'(w_log[cur_wa + i]), 64'(cur_k[32 * i +: 32]));
    end
    check("protocol_order", 64'(proto_err), 64'd0);
    check("stable_while_valid", 64'(stab_err), 64'd0);
  endtask

  initial begin
    logic [255:0] k1, k3, k4, k5;
    rst_n = 1'b0; start = 1'b0; key = '0; base_addr = '0;
    for (int i = 0; i < 32; i++) k1[8 * i +: 8] = 8'(i);
    for (int i = 0; i < 8; i++) begin
      k3[32 * i +: 32] = 32'hA5C30000 | 32'(i);
      k4[32 * i +: 32] = $urandom;
      k5[32 * i +: 32] = $urandom;
    end

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_idx", 64'(err_idx), 64'd0);
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_bready", 64'(bready), 64'd0);
    check("rst_awaddr", 64'(awaddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("awprot_zero", 64'(awprot), 64'd0);
    check("wstrb_ones", 64'(wstrb), 64'hF);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: always-ready slave, byte-pattern key
    begin_load(k1, 32'h0A00A000, 8'h00);
    check("t1_word0_data", 64'(wdata), 64'h03020100);
    end_load(17, 0, 1'b0, 3'd0);
    check("t1_last_addr", 64'(aw_log[cur_a + 7]), 64'h0A00A01C);
    check("t1_last_data", 64'(w_log[cur_wa + 7]), 64'h1F1E1D1C);

    // T2: AW stalled 3 cycles, then W stalled 3 cycles -> 5 cycles per word
    aw_lat = 3; w_lat = 0;
    begin_load(k1, 32'h0A00A000, 8'h00);
    end_load(41, 0, 1'b0, 3'd0);
    aw_lat = 0; w_lat = 3;
    begin_load(k3, 32'h10000040, 8'h00);
    end_load(41, 0, 1'b0, 3'd0);
    w_lat = 0;

    // T3: error responses on words 2 and 5, then the next start clears err
    begin_load(k3, 32'h20000000, 8'b0010_0100);
    end_load(17, 0, 1'b1, 3'd2);
    check("t3_err_sticky", 64'(err), 64'd1);
    begin_load(k1, 32'h20000100, 8'h00);
    end_load(17, 0, 1'b0, 3'd0);

    // T4: start pulsed mid-load with a different key is ignored
    begin_load(k4, 32'h30000000, 8'h00);
    end_load(17, 5, 1'b0, 3'd0);

    // T5: address wrap past 2^32
    begin_load(k5, 32'hFFFFFFF8, 8'h00);
    end_load(17, 0, 1'b0, 3'd0);
    check("t5_addr1", 64'(aw_log[cur_a + 1]), 64'hFFFFFFFC);
    check("t5_addr2", 64'(aw_log[cur_a + 2]), 64'h00000000);
    check("t5_addr7", 64'(aw_log[cur_a + 7]), 64'h00000014);

    // T6: reset during word 3 XFER (7 cycles per word with 5-cycle stalls)
    aw_lat = 5; w_lat = 5;
    begin_load(k4, 32'h40000000, 8'h00);
    repeat (23) @(negedge clk);
    check("t6_awvalid_pre", 64'(awvalid), 64'd1);
    check("t6_awaddr_pre", 64'(awaddr), 64'h4000000C);
    rst_n = 1'b0;
    #1;
    check("t6_awvalid_rst", 64'(awvalid), 64'd0);
    check("t6_wvalid_rst", 64'(wvalid), 64'd0);
    check("t6_busy_rst", 64'(busy), 64'd0);
    check("t6_words_written", 64'(aw_n - cur_a), 64'd3);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    aw_lat = 0; w_lat = 0;
    @(negedge clk);
    check("t6_idle_after_rst", 64'(busy), 64'd0);
    begin_load(k5, 32'h50000000, 8'h00);
    end_load(17, 0, 1'b0, 3'd0);

    // T7: start during the DONE cycle is ignored, accepted on the following cycle
    begin_load(k3, 32'h60000000, 8'h00);
    repeat (16) @(negedge clk);
    check("t7_done_pre", 64'(done), 64'd0);
    check("t7_busy_pre", 64'(busy), 64'd1);
    key = k1; base_addr = 32'h70000000; start = 1'b1;
    @(negedge clk);
    check("t7_done_pulse", 64'(done), 64'd1);
    check("t7_start_ignored", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("t7_start_accepted", 64'(busy), 64'd1);
    check("t7_done_single", 64'(done), 64'd0);
    bad_mask = 8'h00; cur_k = k1; cur_b = 32'h70000000; cur_a = aw_n; cur_wa = w_n; b_base = b_n;
    end_load(17, 0, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
